nbit_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at width N. It sits beside the single-cycle ALU in the execute stage. The core issues one operation with a start pulse, stalls while busy is high, and collects the result on a one-cycle done pulse. Multiplication is radix-2 shift-add and division is radix-2 restoring, one bit per cycle. A kill input aborts the operation on a pipeline flush.

---
 rtl/nbit_muldiv_unit.sv | 96 +++++++++
 tb/tb_nbit_muldiv_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nbit_muldiv_unit.sv
// nbit_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle
module nbit_muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]    state;
  logic [2:0]    op_r;
  logic          sa, sb;
  logic [N-1:0]  d;
  logic [2*N-1:0] acc;
  logic [CW-1:0] count;
  logic          a_sgn, b_sgn, div_zero, ovf, bypass;
  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    mul_sum, sh;
  logic          ok;
  logic [N-1:0]  diff, rem_next, hi, lo, quot, rem;
  logic [2*N-1:0] mul_next, div_next, prod;
  logic [N-1:0]  fin_res;
  always_comb begin
    a_sgn    = a[N-1] & (op[2] ? ~op[0] : (op[0] ^ op[1]));
    b_sgn    = b[N-1] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
    a_mag    = a_sgn ? -a : a;
    b_mag    = b_sgn ? -b : b;
    div_zero = op[2] & (b == '0);
    ovf      = op[2] & ~op[0] & (a == {1'b1, {(N-1){1'b0}}}) & (&b);
    bypass   = div_zero | ovf;
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, d} : '0);
    mul_next = {mul_sum, acc[N-1:1]};
    sh       = {acc[2*N-1:N], acc[N-1]};
    ok       = sh >= {1'b0, d};
    diff     = sh[N-1:0] - d;
    rem_next = ok ? diff : sh[N-1:0];
    div_next = {rem_next, acc[N-2:0], ok};
    hi       = acc[2*N-1:N];
    lo       = acc[N-1:0];
    prod     = (sa ^ sb) ? -acc : acc;
    quot     = (sa ^ sb) ? -lo : lo;
    rem      = sa ? -hi : hi;
    fin_res  = op_r[2] ? (op_r[1] ? rem : quot)
                       : (op_r[1:0] == 2'b00 ? prod[N-1:0] : prod[2*N-1:N]);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      acc    <= '0;
      d      <= '0;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (start) begin
          op_r  <= op;
          count <= CW'(N);
          d     <= op[2] ? b_mag : a_mag;
          // bypass results are preloaded so FIN's sign fix-up is a no-op
          sa    <= a_sgn & ~bypass;
          sb    <= b_sgn & ~bypass;
          state <= bypass ? FIN : CALC;
          acc   <= div_zero ? {a, {N{1'b1}}}
                 : ovf      ? {{N{1'b0}}, a}
                 : {{N{1'b0}}, op[2] ? a_mag : b_mag};
        end
      end else if (state == CALC) begin
        acc   <= op_r[2] ? div_next : mul_next;
        count <= count - 1'b1;
        if (count == CW'(1)) state <= FIN;
      end else begin
        result <= fin_res;
        done   <= 1'b1;
        state  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_nbit_muldiv_unit.sv
// tb_nbit_muldiv_unit: scoreboard bench for the iterative mul/div unit
module tb_nbit_muldiv_unit;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0] op_i = '0;
  logic [N-1:0] a_i = '0, b_i = '0;
  logic busy, done;
  logic [N-1:0] result;
  logic [N-1:0] q[$];
  int npass = 0, ntot = 0, ndone = 0, nexp = 0;
  nbit_muldiv_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op_i),
    .a(a_i), .b(b_i), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin p = sa / sb; return b == 0 ? 32'hFFFFFFFF : p[31:0]; end
      3'd5: begin p = ua / ub; return b == 0 ? 32'hFFFFFFFF : p[31:0]; end
      3'd6: begin p = sa % sb; return b == 0 ? a : p[31:0]; end
      default: begin p = ua % ub; return b == 0 ? a : p[31:0]; end
    endcase
  endfunction
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (q.size() == 0) chk("unexpected_done", done, 1'b0);
      else chk("result", result, q.pop_front());
    end
  end
  task automatic start_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input int lat, input int nb_exp, input int poke, input string tag);
    int n, nb;
    n = 0;
    nb = busy;
    while (n < 200 && !done) begin
      @(posedge clk);
      n++;
      #1;
      if (n == poke) begin op_i = 3'd5; a_i = 32'd1; b_i = 32'd1; end
      start = (n == poke);
      nb += busy;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy_cycles"}, nb, nb_exp);
  endtask
  task automatic run(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                     input int lat, input string tag, input int poke = 0);
    q.push_back(model(op, a, b));
    nexp++;
    start_op(op, a, b);
    wait_done(lat, lat, poke, tag);
  endtask
  initial begin
    logic [N-1:0] prev;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst result", result, '0);
    rst = 1'b0;
    run(3'd0, 32'd7, 32'hFFFFFFFD, N + 1, "mul");
    run(3'd1, 32'h80000000, 32'h80000000, N + 1, "mulh");
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, N + 1, "mulhu");
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, N + 1, "mulhsu");
    run(3'd4, 32'hFFFFFFF9, 32'd2, N + 1, "div");
    run(3'd6, 32'hFFFFFFF9, 32'd2, N + 1, "rem");
    run(3'd5, 32'd100, 32'd7, N + 1, "divu");
    run(3'd7, 32'd100, 32'd7, N + 1, "remu");
    run(3'd4, 32'd5, 32'd0, 1, "div_by_zero");
    run(3'd7, 32'd5, 32'd0, 1, "remu_by_zero");
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 1, "div_ovf");
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, "rem_ovf");
    run(3'd0, 32'h1234, 32'h5678, N + 1, "mul_poke", 5);
    run(3'd4, 32'hFFFFFF00, 32'd16, N + 1, "b2b_first");
    run(3'd3, 32'hDEADBEEF, 32'h0000FFFF, N + 1, "b2b_second");
    for (int i = 0; i < 16; i++) begin
      logic [2:0] rop;
      logic [N-1:0] ra, rb;
      rop = 3'($urandom_range(7));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'($urandom_range(9)) : $urandom;
      run(rop, ra, rb, (rop[2] && rb == 0) ? 1 : N + 1, "random");
    end
    prev = result;
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill busy", busy, 1'b0);
    chk("kill done", done, 1'b0);
    repeat (40) @(posedge clk);
    #1 chk("kill result", result, prev);
    run(3'd0, 32'd3, 32'd4, N + 1, "mul_after_kill");
    @(negedge clk);
    op_i = 3'd0; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    chk("kill_start busy", busy, 1'b0);
    start_op(3'd4, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst result", result, '0);
    rst = 1'b0;
    run(3'd5, 32'd9, 32'd3, N + 1, "divu_after_rst");
    repeat (40) @(posedge clk);
    chk("done count", ndone, nexp);
    chk("queue empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
